// File: rtl/ps2_host_tx_if.sv
// Command/status and open-drain line bundle between a PS/2 host transmitter and its user.
// master drives the command and the raw lines; slave is the transmitter.
interface ps2_host_tx_if;
  logic [7:0] i_data;
  logic       i_send;
  logic       i_ps2_clk;
  logic       i_ps2_data;
  logic       o_ps2_clk_oe;
  logic       o_ps2_data_oe;
  logic       o_busy;
  logic       o_done;
  logic       o_error;

  modport master (
    output i_data, i_send, i_ps2_clk, i_ps2_data,
    input  o_ps2_clk_oe, o_ps2_data_oe, o_busy, o_done, o_error
  );

  modport slave (
    input  i_data, i_send, i_ps2_clk, i_ps2_data,
    output o_ps2_clk_oe, o_ps2_data_oe, o_busy, o_done, o_error
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte (LSB first, odd parity).
// Line enables only request a low level; the top level ties each line to 0 when set.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 8
) (
  input logic          clk,
  input logic          rst_n,
  ps2_host_tx_if.slave bus
);
  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  // RELEASE still holds the clock low, so INHIBIT ends one cycle early
  localparam logic [INH_W-1:0] INH_LAST =
    (INHIBIT_CYCLES >= 2) ? INH_W'(INHIBIT_CYCLES - 2) : '0;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RELEASE, S_SEND, S_ACK, S_WAIT_IDLE
  } state_t;

  logic [1:0] w_raw;
  logic [1:0] w_filt;
  assign w_raw = {bus.i_ps2_data, bus.i_ps2_clk};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_filt
      logic                  r_sync1;
      logic                  r_sync2;
      logic [FILTER_LEN-1:0] r_shift;
      logic                  r_level;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sync1 <= 1'b1;
          r_sync2 <= 1'b1;
          r_shift <= '1;
          r_level <= 1'b1;
        end else begin
          r_sync1 <= w_raw[gi];
          r_sync2 <= r_sync1;
          r_shift <= {r_shift[FILTER_LEN-2:0], r_sync2};
          if (&r_shift)       r_level <= 1'b1;
          else if (~|r_shift) r_level <= 1'b0;
        end
      end
      assign w_filt[gi] = r_level;
    end
  endgenerate

  logic w_clk_f, w_data_f, w_fall, w_timeout;
  assign w_clk_f  = w_filt[0];
  assign w_data_f = w_filt[1];

  state_t           r_state, w_state_next;
  logic [INH_W-1:0] r_inh_cnt, w_inh_cnt_next;
  logic [TO_W-1:0]  r_to_cnt, w_to_cnt_next;
  logic [3:0]       r_bit_idx, w_bit_idx_next;
  logic [7:0]       r_byte, w_byte_next;
  logic             r_par, w_par_next;
  logic             r_clk_oe, w_clk_oe_next;
  logic             r_data_oe, w_data_oe_next;
  logic             r_busy, w_busy_next;
  logic             r_done, w_done_next;
  logic             r_error, w_error_next;
  logic             r_clk_f_d;

  assign w_fall    = r_clk_f_d & ~w_clk_f;
  assign w_timeout = (r_to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_inh_cnt <= '0;
      r_to_cnt  <= '0;
      r_bit_idx <= '0;
      r_byte    <= '0;
      r_par     <= 1'b0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_clk_f_d <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_inh_cnt <= w_inh_cnt_next;
      r_to_cnt  <= w_to_cnt_next;
      r_bit_idx <= w_bit_idx_next;
      r_byte    <= w_byte_next;
      r_par     <= w_par_next;
      r_clk_oe  <= w_clk_oe_next;
      r_data_oe <= w_data_oe_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
      r_error   <= w_error_next;
      r_clk_f_d <= w_clk_f;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_inh_cnt_next = r_inh_cnt;
    w_to_cnt_next  = r_to_cnt;
    w_bit_idx_next = r_bit_idx;
    w_byte_next    = r_byte;
    w_par_next     = r_par;
    w_clk_oe_next  = r_clk_oe;
    w_data_oe_next = r_data_oe;
    w_busy_next    = r_busy;
    w_done_next    = 1'b0;
    w_error_next   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_send) begin
          w_byte_next    = bus.i_data;
          w_par_next     = ~^bus.i_data;
          w_busy_next    = 1'b1;
          w_clk_oe_next  = 1'b1;
          w_inh_cnt_next = '0;
          w_state_next   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (r_inh_cnt == INH_LAST) begin
          w_data_oe_next = 1'b1;
          w_state_next   = S_RELEASE;
        end else begin
          w_inh_cnt_next = r_inh_cnt + 1'b1;
        end
      end
      S_RELEASE: begin
        w_clk_oe_next  = 1'b0;
        w_data_oe_next = 1'b1;
        w_to_cnt_next  = '0;
        w_bit_idx_next = '0;
        w_state_next   = S_SEND;
      end
      S_SEND, S_ACK, S_WAIT_IDLE: begin
        if (w_timeout) begin
          w_clk_oe_next  = 1'b0;
          w_data_oe_next = 1'b0;
          w_error_next   = 1'b1;
          w_busy_next    = 1'b0;
          w_state_next   = S_IDLE;
        end else begin
          w_to_cnt_next = r_to_cnt + 1'b1;
          if (r_state == S_SEND && w_fall) begin
            w_bit_idx_next = r_bit_idx + 4'd1;
            if (r_bit_idx < 4'd8) begin
              w_data_oe_next = ~r_byte[r_bit_idx[2:0]];
            end else if (r_bit_idx == 4'd8) begin
              w_data_oe_next = ~r_par;
            end else begin
              w_data_oe_next = 1'b0;
              w_state_next   = S_ACK;
            end
          end else if (r_state == S_ACK && w_fall) begin
            if (!w_data_f) begin
              w_state_next = S_WAIT_IDLE;
            end else begin
              w_error_next = 1'b1;
              w_busy_next  = 1'b0;
              w_state_next = S_IDLE;
            end
          end else if (r_state == S_WAIT_IDLE && w_clk_f && w_data_f) begin
            w_done_next  = 1'b1;
            w_busy_next  = 1'b0;
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign bus.o_ps2_clk_oe  = r_clk_oe;
  assign bus.o_ps2_data_oe = r_data_oe;
  assign bus.o_busy        = r_busy;
  assign bus.o_done        = r_done;
  assign bus.o_error       = r_error;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple open-drain PS/2 device model.
module tb_ps2_host_tx;
  localparam int INH = 20;
  localparam int FL  = 4;
  localparam int TO  = 2000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ps2_host_tx_if bus ();
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  assign bus.i_ps2_clk  = ~(bus.o_ps2_clk_oe | dev_clk_low);
  assign bus.i_ps2_data = ~(bus.o_ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int   cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, done_busy_bad = 0;
  int   cyc_rel = 0, cyc_err = 0;
  logic prev_clk_oe = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (bus.o_done) begin
      done_cnt++;
      if (bus.o_busy) done_busy_bad++;
    end
    if (bus.o_error) begin
      err_cnt++;
      cyc_err = cyc;
    end
    if (bus.o_done && bus.o_error) both_cnt++;
    if (prev_clk_oe && !bus.o_ps2_clk_oe) cyc_rel = cyc;
    prev_clk_oe = bus.o_ps2_clk_oe;
  end

  task automatic start_send(input logic [7:0] d);
    @(negedge clk);
    bus.i_data = d;
    bus.i_send = 1'b1;
    @(negedge clk);
    bus.i_send = 1'b0;
  endtask

  task automatic wait_release(output int low_cycles, output logic data_at_rel, output logic busy_at_rel);
    low_cycles = 0;
    for (int n = 0; n < 200 && bus.o_ps2_clk_oe; n++) begin
      low_cycles++;
      @(negedge clk);
    end
    data_at_rel = bus.o_ps2_data_oe;
    busy_at_rel = bus.o_busy;
  endtask

  // Device: 20 cycles high, 20 low; samples data at each rise; ACK low before the 11th fall.
  task automatic device(input int n_falls, input bit ack, output logic [9:0] bits);
    bits = '0;
    for (int i = 0; i < n_falls; i++) begin
      repeat (15) @(negedge clk);
      if (i == 10 && ack) dev_data_low = 1'b1;
      repeat (5) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (20) @(negedge clk);
      dev_clk_low = 1'b0;
      if (i < 10) bits[i] = bus.i_ps2_data;
    end
    dev_data_low = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    for (int n = 0; n < 200 && done_cnt == d0; n++) @(negedge clk);
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [4:0] outs;
    #22;
    outs = {bus.o_ps2_clk_oe, bus.o_ps2_data_oe, bus.o_busy, bus.o_done, bus.o_error};
    n_cmp++;
    if (outs !== 5'b0) begin n_bad++; $display("FAIL reset_outputs: got %b expected 00000", outs); end
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(negedge clk);
    outs = {bus.o_ps2_clk_oe, bus.o_ps2_data_oe, bus.o_busy, bus.o_done, bus.o_error};
    n_cmp++;
    if (outs !== 5'b0) begin n_bad++; $display("FAIL idle_outputs: got %b expected 00000", outs); end
    start_send(8'hA5);
    repeat (5) @(negedge clk);
    n_cmp++;
    if (bus.o_ps2_clk_oe !== 1'b1) begin n_bad++; $display("FAIL inhibit_clk_oe: got %b expected 1", bus.o_ps2_clk_oe); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.o_ps2_clk_oe !== 1'b0 || bus.o_busy !== 1'b0) begin
      n_bad++; $display("FAIL async_reset_inhibit: got clk_oe=%b busy=%b expected 0 0", bus.o_ps2_clk_oe, bus.o_busy);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_send_ed;
    int low, d0, e0; logic drel, brel; logic [9:0] bits;
    d0 = done_cnt; e0 = err_cnt;
    start_send(8'hED);
    wait_release(low, drel, brel);
    n_cmp++;
    if (low !== INH) begin n_bad++; $display("FAIL ed_inhibit_len: got %0d expected %0d", low, INH); end
    n_cmp++;
    if (drel !== 1'b1 || brel !== 1'b1) begin n_bad++; $display("FAIL ed_release: got data_oe=%b busy=%b expected 1 1", drel, brel); end
    device(11, 1'b1, bits);
    n_cmp++;
    if (bits !== 10'h3ED) begin n_bad++; $display("FAIL ed_bits: got %h expected 3ed", bits); end
    wait_done(d0);
    n_cmp++;
    if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL ed_done_count: got %0d expected 1", done_cnt - d0); end
    n_cmp++;
    if (done_busy_bad !== 0 || bus.o_busy !== 1'b0) begin
      n_bad++; $display("FAIL ed_busy_drop: got busy_at_done=%0d busy=%b expected 0 0", done_busy_bad, bus.o_busy);
    end
    n_cmp++;
    if (err_cnt !== e0 || both_cnt !== 0) begin n_bad++; $display("FAIL ed_no_error: got %0d expected 0", err_cnt - e0 + both_cnt); end
  endtask

  task automatic test_send_f4;
    int low, d0, e0; logic drel, brel; logic [9:0] bits;
    d0 = done_cnt; e0 = err_cnt;
    start_send(8'hF4);
    wait_release(low, drel, brel);
    device(11, 1'b1, bits);
    n_cmp++;
    if (bits !== 10'h2F4) begin n_bad++; $display("FAIL f4_bits: got %h expected 2f4", bits); end
    wait_done(d0);
    n_cmp++;
    if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL f4_done_count: got %0d expected 1", done_cnt - d0); end
    n_cmp++;
    if (err_cnt !== e0) begin n_bad++; $display("FAIL f4_no_error: got %0d expected 0", err_cnt - e0); end
  endtask

  task automatic test_nack;
    int low, d0, e0; logic drel, brel; logic [9:0] bits;
    d0 = done_cnt; e0 = err_cnt;
    start_send(8'hED);
    wait_release(low, drel, brel);
    device(11, 1'b0, bits);
    for (int n = 0; n < 200 && err_cnt == e0; n++) @(negedge clk);
    repeat (20) @(negedge clk);
    n_cmp++;
    if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL nack_error_count: got %0d expected 1", err_cnt - e0); end
    n_cmp++;
    if (done_cnt !== d0) begin n_bad++; $display("FAIL nack_no_done: got %0d expected 0", done_cnt - d0); end
    n_cmp++;
    if ({bus.o_ps2_clk_oe, bus.o_ps2_data_oe, bus.o_busy} !== 3'b000) begin
      n_bad++; $display("FAIL nack_idle: got %b expected 000", {bus.o_ps2_clk_oe, bus.o_ps2_data_oe, bus.o_busy});
    end
  endtask

  task automatic test_timeout;
    int low, d0, e0; logic drel, brel; logic [9:0] bits;
    d0 = done_cnt; e0 = err_cnt;
    start_send(8'hF4);
    wait_release(low, drel, brel);
    device(4, 1'b0, bits);
    for (int n = 0; n < 3000 && err_cnt == e0; n++) @(negedge clk);
    repeat (5) @(negedge clk);
    n_cmp++;
    if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL timeout_error_count: got %0d expected 1", err_cnt - e0); end
    n_cmp++;
    if (cyc_err - cyc_rel !== TO) begin n_bad++; $display("FAIL timeout_latency: got %0d expected %0d", cyc_err - cyc_rel, TO); end
    n_cmp++;
    if ({bus.o_ps2_clk_oe, bus.o_ps2_data_oe, bus.o_busy} !== 3'b000 || done_cnt !== d0) begin
      n_bad++; $display("FAIL timeout_release: got oe/busy=%b done=%0d expected 000 0",
                        {bus.o_ps2_clk_oe, bus.o_ps2_data_oe, bus.o_busy}, done_cnt - d0);
    end
  endtask

  task automatic test_ignore_send;
    int low, d0; logic drel, brel; logic [9:0] bits;
    d0 = done_cnt;
    start_send(8'hED);
    wait_release(low, drel, brel);
    fork
      device(11, 1'b1, bits);
      begin
        repeat (100) @(negedge clk);
        bus.i_data = 8'h00;
        bus.i_send = 1'b1;
        @(negedge clk);
        bus.i_send = 1'b0;
      end
    join
    wait_done(d0);
    repeat (40) @(negedge clk);
    n_cmp++;
    if (bits !== 10'h3ED) begin n_bad++; $display("FAIL ignore_bits: got %h expected 3ed", bits); end
    n_cmp++;
    if (done_cnt - d0 !== 1 || bus.o_busy !== 1'b0) begin
      n_bad++; $display("FAIL ignore_done: got done=%0d busy=%b expected 1 0", done_cnt - d0, bus.o_busy);
    end
  endtask

  task automatic test_reset_mid;
    int low, d0, e0; logic drel, brel; logic [9:0] bits;
    d0 = done_cnt; e0 = err_cnt;
    start_send(8'hED);
    wait_release(low, drel, brel);
    device(5, 1'b0, bits);
    n_cmp++;
    if (bus.o_ps2_data_oe !== 1'b1) begin n_bad++; $display("FAIL mid_data_oe_k5: got %b expected 1", bus.o_ps2_data_oe); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.o_ps2_clk_oe, bus.o_ps2_data_oe} !== 2'b00) begin
      n_bad++; $display("FAIL mid_async_release: got %b expected 00", {bus.o_ps2_clk_oe, bus.o_ps2_data_oe});
    end
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (done_cnt !== d0 || err_cnt !== e0) begin
      n_bad++; $display("FAIL mid_no_pulse: got done=%0d err=%0d expected 0 0", done_cnt - d0, err_cnt - e0);
    end
    start_send(8'h01);
    wait_release(low, drel, brel);
    device(11, 1'b1, bits);
    n_cmp++;
    if (bits !== 10'h201) begin n_bad++; $display("FAIL after_reset_bits: got %h expected 201", bits); end
    wait_done(d0);
    n_cmp++;
    if (done_cnt - d0 !== 1 || err_cnt !== e0) begin
      n_bad++; $display("FAIL after_reset_done: got done=%0d err=%0d expected 1 0", done_cnt - d0, err_cnt - e0);
    end
  endtask

  initial begin
    bus.i_data = 8'h00;
    bus.i_send = 1'b0;
    test_reset();
    test_send_ed();
    test_send_f4();
    test_nack();
    test_timeout();
    test_ignore_send();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
